// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the handshaked ALU.
//   - opcode encodings (INST field)
//   - FLAGS bit positions
//   - control FSM state encoding
//   - pack_flags(): assembles the 4-bit FLAGS word (bit 3 reserved, always 0)
package alu_pkg;

  localparam logic [3:0] INCA   = 4'd0;
  localparam logic [3:0] DECA   = 4'd1;
  localparam logic [3:0] ADD    = 4'd2;
  localparam logic [3:0] SUB    = 4'd3;
  localparam logic [3:0] ABS    = 4'd4;
  localparam logic [3:0] NEGA   = 4'd5;
  localparam logic [3:0] MUL    = 4'd6;
  localparam logic [3:0] NEGB   = 4'd7;
  localparam logic [3:0] AND    = 4'd8;
  localparam logic [3:0] OR     = 4'd9;
  localparam logic [3:0] XOR    = 4'd10;
  localparam logic [3:0] INVB   = 4'd11;
  localparam logic [3:0] PASSA  = 4'd12;
  localparam logic [3:0] INVA   = 4'd13;
  localparam logic [3:0] ZEROES = 4'd14;
  localparam logic [3:0] ONES   = 4'd15;

  localparam int FLAG_OVF = 0;
  localparam int FLAG_C   = 1;
  localparam int FLAG_Z   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  function automatic logic [3:0] pack_flags(input logic zero, input logic carry,
                                            input logic ovf);
    logic [3:0] f;
    f           = '0;
    f[FLAG_Z]   = zero;
    f[FLAG_C]   = carry;
    f[FLAG_OVF] = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add unsigned multiplier, one multiplier bit
// per clock.
//   clk, rst  : clock, async active-high reset (clears counter -> idle)
//   start     : load a/b and begin; counter set to WIDTH
//   a, b      : multiplicand / multiplier
//   done      : high in the cycle whose edge processes the last bit
//   prod      : low half of the product, valid while done (combinational,
//               so the caller can register it on that same edge)
//   hi_nz     : high half of the product is nonzero, valid while done
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod,
  output logic             hi_nz
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy;

  assign busy    = (cnt != '0);
  assign done    = (cnt == CW'(1));
  // Partial sum after the current bit; on the last step this is the product.
  assign acc_nxt = mplier[0] ? acc + mcand : acc;
  assign prod    = acc_nxt[WIDTH-1:0];
  assign hi_nz   = |acc_nxt[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= CW'(WIDTH);
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a single-slot registered output.
//   CLOCK, RESET        : clock, async active-high reset
//   IN_VALID / IN_READY : operand handshake (A, B, INST)
//   OUT_VALID/OUT_READY : result handshake (Z, FLAGS)
//   FLAGS               : [0] OVF, [1] Carry, [2] Zero, [3] reserved 0
// Every opcode except MUL completes in one cycle through a shared
// WIDTH+1-bit adder. MUL runs WIDTH cycles in alu_mul_iter while input is
// held off; its result lands directly in the (necessarily empty) output slot.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       INST,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Z,
  output logic [3:0]       FLAGS
);

  localparam int MSB = WIDTH - 1;

  state_t           state;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic             mul_hi_nz;

  // Adder operands and the logic-op result.
  logic [WIDTH-1:0] ax, ay, lz;
  logic             cin, arith;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_z;
  logic             res_c, res_v;

  assign IN_READY  = (state == ST_IDLE) && (!OUT_VALID || OUT_READY);
  assign accept    = IN_VALID && IN_READY;
  assign mul_start = accept && (INST == MUL);

  always_comb begin
    ax    = A;
    ay    = '0;
    cin   = 1'b0;
    arith = 1'b1;
    lz    = '0;
    case (INST)
      INCA:   cin = 1'b1;
      DECA:   ay  = '1;
      ADD:    ay  = B;
      SUB:    begin ay = ~B; cin = 1'b1; end
      // Non-negative A passes through A + 0 so carry/ovf come out 0.
      ABS:    if (A[MSB]) begin ax = ~A; cin = 1'b1; end
      NEGA:   begin ax = ~A; cin = 1'b1; end
      NEGB:   begin ax = ~B; cin = 1'b1; end
      MUL:    arith = 1'b0;
      AND:    begin arith = 1'b0; lz = A & B; end
      OR:     begin arith = 1'b0; lz = A | B; end
      XOR:    begin arith = 1'b0; lz = A ^ B; end
      INVB:   begin arith = 1'b0; lz = ~B; end
      PASSA:  begin arith = 1'b0; lz = A; end
      INVA:   begin arith = 1'b0; lz = ~A; end
      ZEROES: begin arith = 1'b0; lz = '0; end
      ONES:   begin arith = 1'b0; lz = '1; end
      default: arith = 1'b0;
    endcase
    sum   = {1'b0, ax} + {1'b0, ay} + {{WIDTH{1'b0}}, cin};
    res_z = arith ? sum[MSB:0] : lz;
    res_c = arith & sum[WIDTH];
    // Overflow: adder inputs share a sign that the result does not.
    res_v = arith & (ax[MSB] == ay[MSB]) & (sum[MSB] != ax[MSB]);
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (CLOCK),
    .rst   (RESET),
    .start (mul_start),
    .a     (A),
    .b     (B),
    .done  (mul_done),
    .prod  (mul_prod),
    .hi_nz (mul_hi_nz)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      OUT_VALID <= 1'b0;
      Z         <= '0;
      FLAGS     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (INST == MUL) begin
              // Slot is empty or draining this edge; stays empty during MUL.
              state     <= ST_MUL;
              OUT_VALID <= 1'b0;
            end else begin
              OUT_VALID <= 1'b1;
              Z         <= res_z;
              FLAGS     <= pack_flags(res_z == '0, res_c, res_v);
            end
          end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state     <= ST_IDLE;
            OUT_VALID <= 1'b1;
            Z         <= mul_prod;
            FLAGS     <= pack_flags(mul_prod == '0, mul_hi_nz, 1'b0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: two instances (WIDTH=32 and WIDTH=8) on one clock. Directed
// cases use literal expected values; random streams are scored against an
// integer-arithmetic model of the opcode table through a FIFO.
module tb_alu_seq;

  typedef struct packed {
    logic [3:0]  f;
    logic [31:0] z;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, iv0, ird0, ov0, ordy0;
  logic [31:0] a0, b0, z0;
  logic [3:0]  inst0, f0;
  logic        rst1, iv1, ird1, ov1, ordy1;
  logic [7:0]  a1, b1, z1;
  logic [3:0]  inst1, f1;

  alu_seq #(.WIDTH(32)) dut32 (
    .CLOCK(clk), .RESET(rst0), .IN_VALID(iv0), .IN_READY(ird0), .A(a0), .B(b0),
    .INST(inst0), .OUT_VALID(ov0), .OUT_READY(ordy0), .Z(z0), .FLAGS(f0)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .CLOCK(clk), .RESET(rst1), .IN_VALID(iv1), .IN_READY(ird1), .A(a1), .B(b1),
    .INST(inst1), .OUT_VALID(ov1), .OUT_READY(ordy1), .Z(z1), .FLAGS(f1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  res_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- per-instance accessors ----
  function automatic logic [31:0] g_z(input int s);
    return (s != 0) ? {24'b0, z1} : z0;
  endfunction
  function automatic logic [3:0] g_f(input int s);
    return (s != 0) ? f1 : f0;
  endfunction
  function automatic logic g_ov(input int s);
    return (s != 0) ? ov1 : ov0;
  endfunction
  function automatic logic g_ird(input int s);
    return (s != 0) ? ird1 : ird0;
  endfunction

  task automatic set_in(input int s, input logic v, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    if (s != 0) begin iv1 = v; inst1 = op; a1 = a[7:0]; b1 = b[7:0]; end
    else        begin iv0 = v; inst0 = op; a0 = a;      b0 = b;      end
  endtask
  task automatic set_rdy(input int s, input logic r);
    if (s != 0) ordy1 = r; else ordy0 = r;
  endtask

  // ---- reference model: opcode table in plain integer arithmetic ----
  function automatic res_t ref_alu(input int w, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m, ua, ub, full, z;
    longint      sa, sb, smin, smax;
    logic        c, v;
    res_t        r;
    m    = (64'd1 << w) - 1;
    ua   = {32'b0, a} & m;
    ub   = {32'b0, b} & m;
    smax = longint'((64'd1 << (w - 1)) - 1);
    smin = -smax - 1;
    sa   = (ua > 64'(smax)) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb   = (ub > 64'(smax)) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    c = 1'b0; v = 1'b0; z = '0;
    case (op)
      4'd0:  begin z = ua + 1; c = (ua == m); v = (sa + 1 > smax); end
      4'd1:  begin z = ua - 1; c = (ua != 0); v = (sa - 1 < smin); end
      4'd2:  begin full = ua + ub; z = full; c = (full > m);
                   v = (sa + sb > smax) || (sa + sb < smin); end
      4'd3:  begin z = ua - ub; c = (ua >= ub);
                   v = (sa - sb > smax) || (sa - sb < smin); end
      4'd4:  begin if (sa < 0) z = 64'(-sa); else z = ua; v = (sa == smin); end
      4'd5:  begin z = 64'(-sa); c = (ua == 0); v = (sa == smin); end
      4'd6:  begin full = ua * ub; z = full; c = ((full >> w) != 0); end
      4'd7:  begin z = 64'(-sb); c = (ub == 0); v = (sb == smin); end
      4'd8:  z = ua & ub;
      4'd9:  z = ua | ub;
      4'd10: z = ua ^ ub;
      4'd11: z = ~ub;
      4'd12: z = ua;
      4'd13: z = ~ua;
      4'd14: z = '0;
      default: z = m;
    endcase
    z   = z & m;
    r.z = z[31:0];
    r.f = {1'b0, (z == 0), c, v};
    return r;
  endfunction

  // Random operand biased toward the interesting corners.
  function automatic logic [31:0] pick(input int w);
    logic [31:0] m, mn;
    m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    mn = 32'd1 << (w - 1);
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return m;
      2: return mn;
      3: return mn - 1;
      4: return 32'd1;
      default: return $urandom & m;
    endcase
  endfunction

  // One single-cycle op: accepted at next edge, result visible after it.
  task automatic do_op(input int s, input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ez, input logic [3:0] ef);
    @(negedge clk);
    set_rdy(s, 1'b1);
    set_in(s, 1'b1, op, a, b);
    #1 chk({tag, "_ird"}, g_ird(s), 1);
    @(negedge clk);
    set_in(s, 1'b0, 4'd0, 32'd0, 32'd0);
    chk({tag, "_ov"}, g_ov(s), 1);
    chk({tag, "_z"}, g_z(s), ez);
    chk({tag, "_f"}, g_f(s), ef);
  endtask

  task automatic run_stream(input int s, input int n);
    int          w, sent, got, cyc;
    logic        hold, cv, r;
    logic [3:0]  cop;
    logic [31:0] ca, cb;
    res_t        e;
    w = (s != 0) ? 8 : 32;
    sent = 0; got = 0; cyc = 0; hold = 1'b0; cv = 1'b0;
    cop = '0; ca = '0; cb = '0;
    q.delete();
    while (got < n && cyc < 30000) begin
      @(negedge clk);
      if (!hold) begin
        if (sent < n) begin
          cv = 1'b1; cop = 4'($urandom_range(0, 15)); ca = pick(w); cb = pick(w);
        end else cv = 1'b0;
        set_in(s, cv, cop, ca, cb);
      end
      r = ($urandom_range(0, 3) != 0);
      set_rdy(s, r);
      #1;
      if (g_ov(s) && r) begin
        if (q.size() == 0) chk("stream_extra", 1, 0);
        else begin
          e = q.pop_front();
          chk("stream_z", g_z(s), e.z);
          chk("stream_f", g_f(s), e.f);
          got++;
        end
      end
      if (cv && g_ird(s)) begin
        q.push_back(ref_alu(w, cop, ca, cb));
        sent++;
        hold = 1'b0;
      end else hold = cv;
      cyc++;
    end
    chk("stream_count", got, n);
    chk("stream_left", q.size(), 0);
    @(negedge clk);
    set_in(s, 1'b0, 4'd0, 32'd0, 32'd0);
    set_rdy(s, 1'b1);
  endtask

  initial begin
    int seen;
    rst0 = 1'b1; rst1 = 1'b1;
    set_in(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_in(1, 1'b0, 4'd0, 32'd0, 32'd0);
    set_rdy(0, 1'b0); set_rdy(1, 1'b0);
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ov", g_ov(s), 0);
      chk("rst_z", g_z(s), 0);
      chk("rst_f", g_f(s), 0);
      chk("rst_ird", g_ird(s), 1);
    end

    // WIDTH=32 directed
    do_op(0, "add_ovf", 4'd2, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'h1);
    do_op(0, "sub_eq",  4'd3, 32'd5, 32'd5, 32'h0, 4'h6);
    do_op(0, "deca_0",  4'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 4'h0);
    // WIDTH=8 directed
    do_op(1, "abs_min", 4'd4, 32'h80, 32'h0, 32'h80, 4'h1);
    do_op(1, "nega_0",  4'd5, 32'h00, 32'h0, 32'h00, 4'h6);

    // WIDTH=8 MUL 0x10*0x20: READY low 8 cycles, result on 8th edge
    @(negedge clk);
    set_rdy(1, 1'b1);
    set_in(1, 1'b1, 4'd6, 32'h10, 32'h20);
    @(negedge clk);
    set_in(1, 1'b0, 4'd0, 32'd0, 32'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (!ird1 && !ov1) seen++;
    end
    chk("mul_busy_cycles", seen, 8);
    @(negedge clk);
    chk("mul_ov", ov1, 1);
    chk("mul_z", z1, 8'h00);
    chk("mul_f", f1, 4'h6);

    // Reset in the middle of a MUL, with a stale nonzero Z in the register
    @(negedge clk);
    set_rdy(1, 1'b0);
    set_in(1, 1'b1, 4'd12, 32'h5A, 32'h0);
    @(negedge clk);
    set_in(1, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("pre_z", z1, 8'h5A);
    set_rdy(1, 1'b1);
    set_in(1, 1'b1, 4'd6, 32'hFF, 32'hFF);
    @(negedge clk);
    set_in(1, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    rst1 = 1'b1;
    #1;
    chk("midrst_ov", ov1, 0);
    chk("midrst_z", z1, 0);
    chk("midrst_f", f1, 0);
    @(negedge clk);
    rst1 = 1'b0;
    #1 chk("postrst_ird", ird1, 1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov1) seen++;
    end
    chk("no_stale", seen, 0);

    run_stream(1, 200);
    run_stream(0, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 32-bit registered ALU. Width is set by `WIDTH`. Ready/valid flow control sits on both the input and output sides. Opcode 6, previously unsupported, is now an iterative unsigned multiply (low half) that takes `WIDTH` cycles. The block sits between the operand-fetch stage and the writeback stage of the functional unit.

## Interface
- `WIDTH`, default 32: operand/result width, ≥ 4.
- `CLOCK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-high.
- `IN_VALID` in 1: operand/opcode valid.
- `IN_READY` out 1: block accepts this cycle.
- `A` in `WIDTH`: operand A.
- `B` in `WIDTH`: operand B.
- `INST` in 4: opcode.
- `OUT_VALID` out 1: `Z`/`FLAGS` valid.
- `OUT_READY` in 1: consumer takes result.
- `Z` out `WIDTH`: result.
- `FLAGS` out 4: bit 0 OVF, bit 1 Carry, bit 2 Zero, bit 3 reserved (always 0).

## Operation
- Opcodes:
  - 0 `A+1`; 1 `A-1`; 2 `A+B`; 3 `A-B`.
  - 4 `abs(A)`; 5 `-A`; 6 MUL; 7 `-B`.
  - 8 `A&B`; 9 `A|B`; 10 `A^B`; 11 `~B`.
  - 12 `A`; 13 `~A`; 14 zero; 15 all-ones.
- Arithmetic is one `WIDTH+1`-bit adder:
  - `A-1` = A + all-ones; `A-B` = A + ~B + 1.
  - `-A` = ~A + 1; `-B` = ~B + 1.
  - `abs` = A if A[msb]=0, else ~A + 1.
- Carry = adder carry-out. Consequences: `A-B` carry = 1 means no borrow; `A-1` carry = 0 only when A = 0; `-A` carry = 1 only when A = 0.
- OVF = two's-complement overflow: operand signs equal and result sign differs.
  - `abs`/`-A` of most-negative value: Z = 100…0, OVF = 1.
  - `-B` likewise for B.
- Logic and pass opcodes (8–15): OVF = 0, Carry = 0.
- MUL (6): Z = (A·B)[WIDTH-1:0], unsigned. Carry = 1 if the high half is nonzero; OVF = 0.
- Zero = 1 iff Z == 0, for every opcode.
- States:
  - IDLE → MUL on accept with INST = 6.
  - MUL → IDLE when the iteration counter expires.
- `IN_READY` = (state == IDLE) && (!OUT_VALID || OUT_READY).
- Accept = `IN_VALID && IN_READY`.
- Output register is a single slot. `OUT_VALID` holds with `Z`/`FLAGS` stable until `OUT_READY`.
- `RESET` asserted at any time:
  - state → IDLE, `OUT_VALID` = 0, `Z` = 0, `FLAGS` = 0, counter = 0.
  - An in-flight MUL is discarded.
  - `IN_READY` is 1 in the first cycle after `RESET` deasserts.

## Timing
- Single-cycle opcodes: latency 1. Result is registered on the accepting edge, so `OUT_VALID` is high in the following cycle.
- Back-to-back throughput: 1 per cycle while `OUT_READY` = 1.
- Drain and refill on the same edge is allowed: output consumed and a new result loaded.
- MUL timing:
  - Accepting edge loads multiplicand, multiplier, accumulator, and counter = `WIDTH`.
  - One bit is processed per edge.
  - Result is written and `OUT_VALID` rises on the `WIDTH`-th edge after accept.
  - `IN_READY` = 0 for those `WIDTH` cycles.
- During MUL the output slot is always empty: it was empty or drained at the accepting edge. Completion never stalls.
- `OUT_READY` while `OUT_VALID` = 0 has no effect.
- `IN_VALID` while `IN_READY` = 0: ignored. The producer must hold its data.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams (INCA, DECA, ADD, SUB, ABS, NEGA, MUL, NEGB, AND, OR, XOR, INVB, PASSA, INVA, ZEROES, ONES);
  - flag bit indices (`FLAG_OVF` = 0, `FLAG_C` = 1, `FLAG_Z` = 2);
  - state encoding.
- Sub-module `alu_mul_iter` (parameter `WIDTH`): shift-add multiplier with start/done, low-half result, and a high-half-nonzero output.
- Top level holds the combinational datapath, handshake, FSM and output register.

## Test plan
- `WIDTH` = 32, ADD, A = 7FFFFFFF, B = 1 → next cycle Z = 80000000, FLAGS = 1 (OVF only).
- `WIDTH` = 32, SUB, A = 5, B = 5 → Z = 0, FLAGS = 6 (Carry, Zero). Also DECA, A = 0 → Z = FFFFFFFF, FLAGS = 0.
- `WIDTH` = 8, ABS, A = 80 → Z = 80, OVF = 1. NEGA, A = 00 → Z = 00, FLAGS = 6.
- `WIDTH` = 8, MUL, A = 10, B = 20:
  - `IN_READY` low for 8 cycles;
  - `OUT_VALID` on the 8th edge;
  - Z = 00, FLAGS = 6 (high half 02 nonzero).
- Stream all 16 opcodes with random data while `OUT_READY` toggles pseudo-randomly → every result matches the reference model in order, with none dropped or duplicated.
- Assert `RESET` mid-MUL (cycle 3 of 8) → `OUT_VALID` = 0, `Z` = 0, `FLAGS` = 0, `IN_READY` = 1 after release; no stale result emerges.
